vco_period_scheduler: RTL and testbench
=======================================

// Module: vco_period_scheduler
// PURPOSE
//  Time-shares one serial divider and one external natural_log unit between NUM_CH
//  555 VCO channels. For a requesting channel it computes
//  cycles_high = CLOCK_RC * ln(1 + v/(2*(VCC-v))) and writes it into that channel's
//  register. The channel's oscillator counter reads the register. Sits between the
//  control-voltage sources and the per-channel oscillator/slew stages.
// PARAMETERS
//  NUM_CH       4     channels served (2..8)
//  CLOCK_RC     4096  clk cycles per C*(R1+R2); shared by all channels
//  LOG_LATENCY  2     fixed clk latency of the external natural_log, log_in -> log_out
//  CH_DEFAULT   1000  reset value of every cycles_high entry
// PORTS
//  clk          in   1          system clock
//  I_RST        in   1          synchronous reset, active-high
//  req          in   NUM_CH     per-channel recompute request; a 1-cycle pulse is sufficient
//  v_control    in   16*NUM_CH  signed control voltages; channel k = bits [16k+15:16k]
//  log_in       out  24         8.8 argument to natural_log
//  log_out      in   12         8-frac ln(log_in); sampled LOG_LATENCY cycles after issue
//  cycles_high  out  32*NUM_CH  per-channel high time in clk cycles
//  upd          out  NUM_CH     1-cycle strobe; the channel's cycles_high was rewritten
//  busy         out  1          a computation is in flight
// BEHAVIOUR
//  - Reset values: every cycles_high = CH_DEFAULT; upd=0; busy=0; log_in=0; pending=0;
//    rr pointer=0; FSM=IDLE. I_RST mid-computation aborts it; no upd is issued.
//  - pending[k] is set by req[k]=1 and cleared in the GRANT cycle of channel k.
//    - A req that arrives while pending is already set coalesces with it.
//    - A req in the grant cycle itself, or during service of k, leaves pending[k]=1.
//      Channel k is then served again later.
//  - FSM: IDLE -> PREP -> DIV(16) -> LOGW(LOG_LATENCY) -> MUL -> WR -> IDLE.
//  - IDLE (grant cycle), taken when any pending bit is set:
//    - Round-robin pick: the first pending index at or after rr, wrapping at NUM_CH.
//    - rr <= grant+1 mod NUM_CH. Latch v = v_control[grant]; later input changes are ignored.
//  - PREP, clamp: v_s = 0 if v<0; 16256 if v>16256; else v.
//    - den = (2*(16384-v_s)) >> 8, so den >= 1 always and divide-by-zero is impossible.
//  - DIV: restoring 16-bit unsigned divide, one quotient bit per cycle, MSB first;
//    q = v_s / den, truncated.
//  - LOGW: log_in = 256 + q, driven in the first LOGW cycle and held until WR.
//    log_out is captured in the last LOGW cycle.
//  - MUL: p = ((CLOCK_RC >> 4) * log_out) >> 4, full 44-bit product.
//    - The result saturates to 32'hFFFF_FFFF if it overflows 32 bits.
//  - WR: cycles_high[grant] <= p; upd[grant]=1 for exactly this cycle.
//    - The FSM is in IDLE next cycle and may grant again then (back-to-back service).
//  - Latency: upd asserts 19+LOG_LATENCY cycles after the grant cycle
//    (21 cycles at LOG_LATENCY=2).
//  - busy=1 from PREP through WR inclusive; 0 in IDLE.
//  - Non-granted channels hold cycles_high unchanged. upd is one-hot or zero.
// CONFIGURATION
//  VCO_SCHED_PRIORITY_EN defined: fixed priority, lowest pending index wins, and rr is
//    unused. Starvation of high indices is permitted.
//  VCO_SCHED_PRIORITY_EN undefined: round-robin exactly as described in BEHAVIOUR.
// TESTING (bench: natural_log stub with LOG_LATENCY=2, returns log_out=100; CLOCK_RC=4096)
//  - Reset: I_RST for 2 cycles -> all cycles_high=1000, upd=0, busy=0, log_in=0.
//  - ch0 v=8192 pulse -> log_in=384; cycles_high[0]=1600; upd[0] exactly 21 cycles
//    after grant.
//  - ch1 v=20000 -> clamped: log_in=16512. ch2 v=-5 -> log_in=256. Both give
//    cycles_high=1600.
//  - Round-robin: with rr=0, req pulses on ch0..ch3 in one cycle -> upd order 0,1,2,3.
//    Grants are back-to-back, 22 cycles apart.
//  - Mid-op: I_RST in a DIV cycle -> no upd; cycles_high back to 1000. A req 1 cycle
//    after reset release is served normally.
//  - PRIORITY_EN: ch3 pending, ch0 re-requested every 10 cycles -> ch0 is served
//    repeatedly and ch3 is not served while ch0 is pending.

Source files
------------

// File: rtl/vco_period_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vco_period_scheduler
// Purpose  : Shares one serial restoring divider and one external natural_log
//            unit between NUM_CH 555-style VCO channels. For a requesting
//            channel it computes
//                cycles_high = CLOCK_RC * ln(1 + v / (2*(VCC - v)))
//            and writes the result into that channel's cycles_high register.
//
// Ports    : clk          system clock
//            I_RST        synchronous reset, active-high
//            req          per-channel recompute request (pulse is enough)
//            v_control    signed 16-bit control voltage per channel
//            log_in       8.8 argument presented to natural_log
//            log_out      8-frac ln(log_in), LOG_LATENCY cycles after issue
//            cycles_high  per-channel high time in clk cycles (32 bits each)
//            upd          one-cycle strobe, channel's cycles_high rewritten
//            busy         a computation is in flight
//
// Config   : VCO_SCHED_PRIORITY_EN defined   -> fixed priority, lowest pending
//                                               index wins (no rr pointer)
//            VCO_SCHED_PRIORITY_EN undefined -> round-robin arbitration
//
// Revision : 1.0  initial release
// ============================================================================
module vco_period_scheduler #(
    parameter int NUM_CH      = 4,
    parameter int CLOCK_RC    = 4096,
    parameter int LOG_LATENCY = 2,
    parameter int CH_DEFAULT  = 1000
) (
    input  logic                   clk,
    input  logic                   I_RST,
    input  logic [NUM_CH-1:0]      req,
    input  logic [16*NUM_CH-1:0]   v_control,
    output logic [23:0]            log_in,
    input  logic [11:0]            log_out,
    output logic [32*NUM_CH-1:0]   cycles_high,
    output logic [NUM_CH-1:0]      upd,
    output logic                   busy
);

    localparam int          c_idx_w   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] c_rc16    = 32'(CLOCK_RC >> 4);
    localparam logic [4:0]  c_div_end = 5'd15;
    localparam logic [4:0]  c_log_end = 5'(LOG_LATENCY - 1);
    // Largest control voltage that keeps 2*(16384-v)>>8 non-zero.
    localparam logic [15:0] c_v_max   = 16'd16256;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_DIV  = 3'd2,
        ST_LOGW = 3'd3,
        ST_MUL  = 3'd4,
        ST_WR   = 3'd5
    } state_t;

    state_t               r_state;
    logic [NUM_CH-1:0]    r_pend;
    logic [c_idx_w-1:0]   r_grant;
    logic [15:0]          r_v;       // latched signed control voltage
    logic [15:0]          r_dvd;     // dividend, becomes quotient MSB-first
    logic [15:0]          r_rem;     // partial remainder
    logic [15:0]          r_den;     // divisor
    logic [4:0]           r_cnt;     // DIV / LOGW cycle counter
    logic [11:0]          r_logv;    // captured natural_log result
    logic [31:0]          r_prod;    // saturated product awaiting WR

    logic                 w_found;
    logic [c_idx_w-1:0]   w_grant;
    logic [NUM_CH-1:0]    w_grant_oh;
    logic [15:0]          w_vs;
    logic [15:0]          w_den;
    logic [16:0]          w_shift;
    logic                 w_ge;
    logic [15:0]          w_rem_next;
    logic [15:0]          w_quo_next;
    logic [43:0]          w_full;
    logic [31:0]          w_sat;

`ifdef VCO_SCHED_PRIORITY_EN
    // Fixed priority: scan from the top so the lowest pending index wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_found = 1'b1;
                w_grant = c_idx_w'(i);
            end
        end
    end
`else
    logic [c_idx_w-1:0]   r_rr;

    // Round-robin: first pending index at or after r_rr, wrapping at NUM_CH.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(r_rr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!w_found && r_pend[idx]) begin
                w_found = 1'b1;
                w_grant = c_idx_w'(idx);
            end
        end
    end
`endif

    // Only a grant in IDLE clears a pending bit.
    assign w_grant_oh = (r_state == ST_IDLE && w_found)
                      ? (NUM_CH'(1) << w_grant) : '0;

    // Clamp the signed voltage into [0, 16256].
    always_comb begin
        if (r_v[15]) begin
            w_vs = 16'd0;
        end else if (r_v > c_v_max) begin
            w_vs = c_v_max;
        end else begin
            w_vs = r_v;
        end
    end

    // den = (2*(16384 - v_s)) >> 8; always >= 1 after the clamp.
    always_comb begin
        logic [16:0] diff2;
        diff2 = {(17'd16384 - {1'b0, w_vs}), 1'b0} >> 1;
        diff2 = diff2 << 1;
        w_den = {8'd0, diff2[15:8]} | {7'd0, diff2[16], 8'd0};
    end

    // One restoring-divide step: shift in next dividend bit, trial subtract.
    assign w_shift    = {r_rem, r_dvd[15]};
    assign w_ge       = (w_shift >= {1'b0, r_den});
    assign w_rem_next = w_ge ? 16'(w_shift - {1'b0, r_den}) : w_shift[15:0];
    assign w_quo_next = {r_dvd[14:0], w_ge};

    // ((CLOCK_RC >> 4) * log_out) >> 4, saturating to 32 bits.
    assign w_full = {12'd0, c_rc16} * {32'd0, r_logv};
    assign w_sat  = (|w_full[43:36]) ? 32'hFFFF_FFFF : w_full[35:4];

    always_ff @(posedge clk) begin
        if (I_RST) begin
            r_state     <= ST_IDLE;
            r_pend      <= '0;
            r_grant     <= '0;
            r_v         <= '0;
            r_dvd       <= '0;
            r_rem       <= '0;
            r_den       <= 16'd1;
            r_cnt       <= '0;
            r_logv      <= '0;
            r_prod      <= '0;
            log_in      <= '0;
            upd         <= '0;
            busy        <= 1'b0;
            cycles_high <= {NUM_CH{32'(CH_DEFAULT)}};
`ifndef VCO_SCHED_PRIORITY_EN
            r_rr        <= '0;
`endif
        end else begin
            // A request in the grant cycle wins over the clear, so the
            // channel is re-served later.
            r_pend <= (r_pend & ~w_grant_oh) | req;

            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_grant;
                        r_v     <= v_control[16*w_grant +: 16];
                        busy    <= 1'b1;
                        r_state <= ST_PREP;
`ifndef VCO_SCHED_PRIORITY_EN
                        r_rr    <= (int'(w_grant) == NUM_CH - 1)
                                 ? '0 : w_grant + c_idx_w'(1);
`endif
                    end
                end

                ST_PREP: begin
                    r_dvd   <= w_vs;
                    r_rem   <= '0;
                    r_den   <= w_den;
                    r_cnt   <= '0;
                    r_state <= ST_DIV;
                end

                ST_DIV: begin
                    r_rem <= w_rem_next;
                    r_dvd <= w_quo_next;
                    if (r_cnt == c_div_end) begin
                        // Quotient is complete this cycle; present it at once.
                        log_in  <= 24'd256 + {8'd0, w_quo_next};
                        r_cnt   <= '0;
                        r_state <= ST_LOGW;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                ST_LOGW: begin
                    if (r_cnt == c_log_end) begin
                        r_logv  <= log_out;
                        r_state <= ST_MUL;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end

                ST_MUL: begin
                    r_prod  <= w_sat;
                    upd     <= NUM_CH'(1) << r_grant;
                    r_state <= ST_WR;
                end

                ST_WR: begin
                    cycles_high[32*r_grant +: 32] <= r_prod;
                    upd     <= '0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    upd     <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vco_period_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_vco_period_scheduler
// Purpose  : Self-checking bench for vco_period_scheduler. A natural_log stub
//            (one register stage, so its output is sampled two cycles after
//            log_in is issued) feeds the DUT; a cycle-level reference model
//            derived from the arithmetic and timing rules predicts busy, upd,
//            log_in and all cycles_high values every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_vco_period_scheduler;

    localparam int N        = 4;
    localparam int CLOCK_RC = 4096;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [16*N-1:0]      vc;
    logic [23:0]          log_in;
    logic [11:0]          log_out;
    logic [32*N-1:0]      ch;
    logic [N-1:0]         upd;
    logic                 busy;

    int                   stub_mode;
    int                   n_total;
    int                   n_bad;

    always #5 clk = ~clk;

    vco_period_scheduler #(
        .NUM_CH      (N),
        .CLOCK_RC    (CLOCK_RC),
        .LOG_LATENCY (2),
        .CH_DEFAULT  (1000)
    ) dut (
        .clk         (clk),
        .I_RST       (rst),
        .req         (req),
        .v_control   (vc),
        .log_in      (log_in),
        .log_out     (log_out),
        .cycles_high (ch),
        .upd         (upd),
        .busy        (busy)
    );

    // natural_log stub: constant 100, or a log_in-dependent pattern that
    // exposes a capture at the wrong cycle.
    function automatic logic [11:0] stub_f(input logic [23:0] li, input int mode);
        return (mode != 0) ? (li[11:0] ^ 12'h5A5) : 12'd100;
    endfunction

    always @(posedge clk) log_out <= stub_f(log_in, stub_mode);

    // ---------------- reference model ----------------
    bit   [N-1:0] m_pend;
    int           m_rr;
    int           m_age;      // cycles since grant; -1 when idle
    int           m_g;
    int           m_v;
    logic [23:0]  m_li;
    logic [11:0]  m_lo;
    logic [31:0]  m_ch [N];

    function automatic int ref_q(input int v);
        int vs, den;
        vs  = (v < 0) ? 0 : ((v > 16256) ? 16256 : v);
        den = (2 * (16384 - vs)) / 256;
        return vs / den;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [11:0] lo);
        longint p;
        p = ((longint'(CLOCK_RC) / 16) * longint'(lo)) / 16;
        if (p > 64'shFFFF_FFFF) return 32'hFFFF_FFFF;
        return p[31:0];
    endfunction

    function automatic int ref_pick();
`ifdef VCO_SCHED_PRIORITY_EN
        for (int i = 0; i < N; i++) if (m_pend[i]) return i;
`else
        for (int i = 0; i < N; i++) if (m_pend[(m_rr + i) % N]) return (m_rr + i) % N;
`endif
        return 0;
    endfunction

    task automatic model_step();
        bit [N-1:0] np;
        if (rst) begin
            m_pend = '0; m_rr = 0; m_age = -1; m_li = '0;
            for (int k = 0; k < N; k++) m_ch[k] = 32'd1000;
            return;
        end
        np = m_pend;
        if (m_age < 0) begin
            if (m_pend != 0) begin
                m_g   = ref_pick();
                m_v   = int'($signed(vc[16*m_g +: 16]));
                np[m_g] = 1'b0;
                m_rr  = (m_g + 1) % N;
                m_age = 1;
            end
        end else begin
            if (m_age == 17) m_li = 24'(256 + ref_q(m_v));
            if (m_age == 19) m_lo = stub_f(m_li, stub_mode);
            if (m_age == 21) begin
                m_ch[m_g] = ref_mul(m_lo);
                m_age = -1;
            end else begin
                m_age++;
            end
        end
        m_pend = np | req;
    endtask

    // ---------------- checking ----------------
    task automatic check_value(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [32*N-1:0] exp_ch;
        logic [N-1:0]    exp_upd;
        for (int k = 0; k < N; k++) exp_ch[32*k +: 32] = m_ch[k];
        exp_upd = (m_age == 21) ? (N'(1) << m_g) : '0;
        check_value("busy",        128'(busy),   128'(m_age >= 1));
        check_value("upd",         128'(upd),    128'(exp_upd));
        check_value("log_in",      128'(log_in), 128'(m_li));
        check_value("cycles_high", 128'(ch),     128'(exp_ch));
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq);
        rst = r;
        req = rq;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (m_age >= 0 || m_pend != 0); i++) step(1'b0, '0);
        step(1'b0, '0);
    endtask

    function automatic logic [15:0] pick_v();
        case ($urandom_range(0, 7))
            0:       return 16'd0;
            1:       return 16'd16256;
            2:       return 16'd16257;
            3:       return 16'hFFFF;
            4:       return 16'h8000;
            5:       return 16'h7FFF;
            6:       return 16'd8192;
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        n_total   = 0;
        n_bad     = 0;
        stub_mode = 0;
        rst       = 1'b1;
        req       = '0;
        vc        = '0;
        m_age     = -1;
        m_pend    = '0;
        m_rr      = 0;
        m_li      = '0;
        for (int k = 0; k < N; k++) m_ch[k] = 32'd1000;
        @(negedge clk);

        // Reset for two cycles.
        step(1'b1, '0);
        step(1'b1, '0);

        // ch0 v=8192 -> log_in 384, cycles_high 1600.
        vc[15:0] = 16'd8192;
        step(1'b0, 4'b0001);
        vc[15:0] = 16'd123;          // later changes must be ignored
        drain();

        // ch1 clamped high, ch2 negative.
        vc[31:16] = 16'd20000;
        step(1'b0, 4'b0010);
        drain();
        vc[47:32] = 16'hFFFB;        // -5
        step(1'b0, 4'b0100);
        drain();

        // All four in one cycle: rr returns to 0 only after a reset.
        step(1'b1, '0);
        vc = {16'd4000, 16'd12000, 16'd300, 16'd16000};
        step(1'b0, 4'b1111);
        drain();

        // Reset during DIV aborts; a request right after release is served.
        vc[63:48] = 16'd1000;
        step(1'b0, 4'b1000);
        idle(8);
        step(1'b1, '0);
        step(1'b0, '0);
        step(1'b0, 4'b0010);
        drain();

        // Randomized traffic with a log_in-dependent log_out.
        stub_mode = 1;
        for (int c = 0; c < 900; c++) begin
            logic [N-1:0] rq;
            for (int k = 0; k < N; k++) begin
                rq[k] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 3) == 0) vc[16*k +: 16] = pick_v();
            end
            step($urandom_range(0, 299) == 0, rq);
        end
        drain();
        stub_mode = 0;

        // ch3 pending while ch0 is re-requested every 10 cycles.
        step(1'b0, 4'b1000);
        for (int c = 0; c < 150; c++) step(1'b0, (c % 10 == 0) ? 4'b0001 : 4'b0000);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
